// File: rtl/uart_midi_tx_pkg.sv
// Shared MIDI UART constants, FSM state types and the status-byte length decoder.
package uart_midi_tx_pkg;

  localparam int MIDI_BYTES        = 3;
  localparam int MIDI_BAUD         = 31250;
  localparam int MIDI_CLKS_PER_BIT = 3147;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic       {EV_IDLE, EV_SEND} ev_state_e;

  // Bytes in an event including status; 0 marks a non-status first byte (reject).
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status[7]) begin
      case (status[6:4])
        3'b100, 3'b101: len = 2'd2;
        3'b111: begin
          case (status)
            8'hF2:        len = 2'd3;
            8'hF1, 8'hF3: len = 2'd2;
            default:      len = 2'd1;
          endcase
        end
        default: len = 2'd3;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/uart_midi_tx_if.sv
// Event handshake and line/status outputs of the MIDI UART transmitter.
interface uart_midi_tx_if #(parameter int MSG_BYTES = 3) ();
  logic                   valid_in;
  logic [MSG_BYTES*8-1:0] midi_bytes;
  logic                   ready_out;
  logic                   tx_out;
  logic                   busy_out;
  logic                   done_out;
  logic                   error_out;

  modport master (output valid_in, midi_bytes,
                  input  ready_out, tx_out, busy_out, done_out, error_out);
  modport slave  (input  valid_in, midi_bytes,
                  output ready_out, tx_out, busy_out, done_out, error_out);
endinterface

// File: rtl/uart_midi_tx_byte.sv
// One 8N1 UART frame per accepted byte; ready rises on the last stop-bit cycle so
// a following byte starts with no idle gap.
module uart_tx_byte
  import uart_midi_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign ready_out = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
  assign tx_out    = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (valid_in) begin
          state_d = TX_START;
          sh_d    = byte_in;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          sh_d = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (valid_in) begin
            state_d = TX_START;
            sh_d    = byte_in;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
    // Line level is registered from the next state so the output never glitches.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = sh_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_midi_tx.sv
// MIDI event transmitter: one event per handshake, 1-3 bytes by status, via uart_tx_byte.
// Optional MIDI_RUNNING_STATUS_EN omits a repeated channel status byte.
module uart_midi_tx
  import uart_midi_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT,
  parameter int MSG_BYTES    = MIDI_BYTES
) (
  input  logic          clk_in,
  input  logic          rst_in,
  uart_midi_tx_if.slave bus
);

  localparam int IW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

  ev_state_e                   state_q, state_d;
  logic [MSG_BYTES-1:0][7:0]   ev_bytes, evt_q, evt_d;
  logic [IW-1:0]               idx_q, idx_d, last_q, last_d, first_idx, idx_nx;
  logic                        done_q, done_d, err_q, err_d;
  logic                        accept, byte_vld, byte_rdy, tx;
  logic [1:0]                  msg_len;
  logic [7:0]                  status, byte_data;

  // Element k holds the k-th byte in transmit order (0 = status).
  always_comb begin
    for (int k = 0; k < MSG_BYTES; k++)
      ev_bytes[k] = bus.midi_bytes[(MSG_BYTES-1-k)*8 +: 8];
  end

  assign status  = ev_bytes[0];
  assign msg_len = midi_msg_len(status);
  assign accept  = bus.valid_in && (state_q == EV_IDLE);
  assign idx_nx  = idx_q + IW'(1);

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q, last_status_d;
  logic       rs_hit;

  always_comb begin
    last_status_d = last_status_q;
    rs_hit        = status[7] && (status < 8'hF0) && (status == last_status_q);
    if (accept && (msg_len != 2'd0)) begin
      if (status < 8'hF0)       last_status_d = status;
      else if (status <= 8'hF7) last_status_d = 8'h00;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) last_status_q <= 8'h00;
    else        last_status_q <= last_status_d;
  end

  assign first_idx = rs_hit ? IW'(1) : '0;
`else
  assign first_idx = '0;
`endif

  always_comb begin
    state_d   = state_q;
    evt_d     = evt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    byte_vld  = 1'b0;
    byte_data = ev_bytes[first_idx];
    case (state_q)
      EV_IDLE: begin
        if (accept) begin
          if (msg_len == 2'd0) begin
            err_d = 1'b1;
          end else begin
            // First byte goes straight from the bus so its start bit begins next cycle.
            state_d  = EV_SEND;
            evt_d    = ev_bytes;
            idx_d    = first_idx;
            last_d   = IW'(msg_len) - IW'(1);
            byte_vld = 1'b1;
          end
        end
      end
      EV_SEND: begin
        if (byte_rdy) begin
          if (idx_q == last_q) begin
            state_d = EV_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_nx;
            byte_vld  = 1'b1;
            byte_data = evt_q[idx_nx];
          end
        end
      end
      default: state_d = EV_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= EV_IDLE;
      evt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .byte_in   (byte_data),
    .valid_in  (byte_vld),
    .ready_out (byte_rdy),
    .tx_out    (tx)
  );

  assign bus.ready_out = (state_q == EV_IDLE);
  assign bus.busy_out  = (state_q == EV_SEND);
  assign bus.done_out  = done_q;
  assign bus.error_out = err_q;
  assign bus.tx_out    = tx;

endmodule
